// File: rtl/riscv_bus_pkg.sv
// Shared definitions for the core's data-side responder: register map, STATUS layout
// and the address decode helper.
package riscv_bus_pkg;

    localparam logic [3:0] TXDATA_OFF  = 4'h0;
    localparam logic [3:0] STATUS_OFF  = 4'h4;
    localparam logic [3:0] TIMER_OFF   = 4'h8;
    localparam logic [3:0] COMPARE_OFF = 4'hC;

    localparam int unsigned STATUS_EMPTY   = 0;
    localparam int unsigned STATUS_FULL    = 1;
    localparam int unsigned STATUS_OVF     = 2;
    localparam int unsigned STATUS_HIT     = 3;
    localparam int unsigned STATUS_CNT_LSB = 4;
    localparam int unsigned STATUS_CNT_W   = 4;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_IO,
        TGT_NONE
    } bus_target_e;

    // RAM wins over the register window should the two ever overlap.
    function automatic bus_target_e decode_target(
        input logic [31:0] addr,
        input logic [31:0] ram_bytes,
        input logic [27:0] io_tag
    );
        bus_target_e tgt;
        if (addr < ram_bytes) begin
            tgt = TGT_RAM;
        end else if (addr[31:4] == io_tag) begin
            tgt = TGT_IO;
        end else begin
            tgt = TGT_NONE;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Transmit FIFO: registered pointers and count, head byte presented on the pop side.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    input  logic                     ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign data    = mem[rd_ptr_q];
    assign count   = count_q;
    assign do_pop  = valid && ready;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Same-cycle data port responder for the single-cycle core: word RAM, a transmit FIFO
// and a free-running timer with a sticky compare flag, all behind one address decode.
module data_bus_responder
    import riscv_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int unsigned IdxW     = $clog2(RAM_WORDS);
    localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

    logic [31:0]     ram [RAM_WORDS];
    logic [IdxW-1:0] ram_idx;

    bus_target_e tgt;
    logic [3:0]  reg_off;
    logic        wr_en;
    logic        ram_we;
    logic        io_we;
    logic        push;
    logic        status_we;
    logic        timer_we;
    logic        compare_we;

    logic            fifo_full;
    logic [CntW-1:0] fifo_count;
    logic            pop;

    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic        ovf_q;
    logic        hit_q;
    logic        ovf_set;
    logic        hit_set;
    logic        ovf_clr;
    logic        hit_clr;
    logic [31:0] status;

    assign tgt     = decode_target(Addr, RamBytes, IO_BASE[31:4]);
    assign reg_off = {Addr[3:2], 2'b00};
    assign ram_idx = Addr[IdxW+1:2];

    assign wr_en      = MemWrite && !reset;
    assign ram_we     = wr_en && (tgt == TGT_RAM);
    assign io_we      = wr_en && (tgt == TGT_IO);
    assign push       = io_we && (reg_off == TXDATA_OFF);
    assign status_we  = io_we && (reg_off == STATUS_OFF);
    assign timer_we   = io_we && (reg_off == TIMER_OFF);
    assign compare_we = io_we && (reg_off == COMPARE_OFF);

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (WriteData[7:0]),
        .full      (fifo_full),
        .valid     (tx_valid),
        .data      (tx_data),
        .ready     (tx_ready),
        .count     (fifo_count)
    );

    assign pop = tx_valid && tx_ready;

    // A full FIFO only drops the byte when no slot frees up in the same cycle.
    assign ovf_set = push && fifo_full && !pop;
    assign hit_set = (timer_q == compare_q);
    assign ovf_clr = status_we && WriteData[STATUS_OVF];
    assign hit_clr = status_we && WriteData[STATUS_HIT];

    assign timer_irq = hit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            ovf_q     <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            timer_q <= timer_we ? WriteData : timer_q + 32'd1;
            if (compare_we) begin
                compare_q <= WriteData;
            end
            // Set takes priority over a clear arriving in the same cycle.
            ovf_q <= ovf_set || (ovf_q && !ovf_clr);
            hit_q <= hit_set || (hit_q && !hit_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= WriteData;
        end
    end

    always_comb begin
        status                                    = '0;
        status[STATUS_EMPTY]                      = !tx_valid;
        status[STATUS_FULL]                       = fifo_full;
        status[STATUS_OVF]                        = ovf_q;
        status[STATUS_HIT]                        = hit_q;
        status[STATUS_CNT_LSB +: STATUS_CNT_W]    = STATUS_CNT_W'(fifo_count);
    end

    always_comb begin
        ReadData = '0;
        unique case (tgt)
            TGT_RAM: ReadData = ram[ram_idx];
            TGT_IO: begin
                unique case (reg_off)
                    STATUS_OFF:  ReadData = status;
                    TIMER_OFF:   ReadData = timer_q;
                    COMPARE_OFF: ReadData = compare_q;
                    default:     ReadData = '0;
                endcase
            end
            default: ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: directed plan items plus randomized traffic,
// checked against a queue/array reference model of the register map.
module tb_data_bus_responder;

    localparam int unsigned RAM_WORDS  = 64;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] IO_BASE    = 32'h0000_FF00;
    localparam logic [31:0] RAM_BYTES  = 32'(RAM_WORDS * 4);
    localparam logic [31:0] A_TX       = IO_BASE + 32'h0;
    localparam logic [31:0] A_ST       = IO_BASE + 32'h4;
    localparam logic [31:0] A_TM       = IO_BASE + 32'h8;
    localparam logic [31:0] A_CMP      = IO_BASE + 32'hC;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        MemWrite  = 1'b0;
    logic [31:0] Addr      = '0;
    logic [31:0] WriteData = '0;
    logic        tx_ready  = 1'b0;
    logic [31:0] ReadData;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        timer_irq;

    always #5 clk = ~clk;

    data_bus_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, advanced at each rising edge.
    logic [7:0]  m_q[$];
    bit          m_ovf   = 1'b0;
    bit          m_hit   = 1'b0;
    logic [31:0] m_timer = '0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    logic [31:0] m_ram [int];
    bit          mon_en  = 1'b0;

    logic [31:0] rd_exp[$];
    string       rd_nm[$];
    bit          rd_chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_io(input logic [31:0] a);
        return (a >= RAM_BYTES) && ((a >> 4) == (IO_BASE >> 4));
    endfunction

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        int off;
        int n;
        off = int'((a % 16) / 4);
        n   = m_q.size();
        v   = '0;
        if (a < RAM_BYTES) begin
            if (!m_ram.exists(int'(a >> 2))) return 1'b0;
            v = m_ram[int'(a >> 2)];
            return 1'b1;
        end
        if (is_io(a)) begin
            case (off)
                1: v = {24'd0, 4'(n), m_hit, m_ovf, n == int'(FIFO_DEPTH), n == 0};
                2: v = m_timer;
                3: v = m_cmp;
                default: v = '0;
            endcase
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit io;
        bit pop;
        bit push;
        bit sel_st;
        bit set_ovf;
        bit set_hit;
        int off;
        if (reset) begin
            m_q.delete();
            m_ovf   = 1'b0;
            m_hit   = 1'b0;
            m_timer = '0;
            m_cmp   = 32'hFFFF_FFFF;
            mon_en  = 1'b1;
        end else begin
            io      = is_io(Addr);
            off     = int'((Addr % 16) / 4);
            pop     = (m_q.size() > 0) && tx_ready;
            push    = MemWrite && io && off == 0;
            sel_st  = MemWrite && io && off == 1;
            set_hit = (m_timer == m_cmp);
            set_ovf = push && (m_q.size() == int'(FIFO_DEPTH)) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !set_ovf) m_q.push_back(WriteData[7:0]);
            m_ovf   = set_ovf || (m_ovf && !(sel_st && WriteData[2]));
            m_hit   = set_hit || (m_hit && !(sel_st && WriteData[3]));
            m_timer = (MemWrite && io && off == 2) ? WriteData : m_timer + 32'd1;
            if (MemWrite && io && off == 3) m_cmp = WriteData;
            if (MemWrite && Addr < RAM_BYTES) m_ram[int'(Addr >> 2)] = WriteData;
        end
    end

    // Monitor: pops the read scoreboard and checks the streaming outputs every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_chk) begin
                if (rd_exp.size() == 0) begin
                    check("rd_scoreboard_underflow", 32'd0, 32'd1);
                end else begin
                    check(rd_nm.pop_front(), ReadData, rd_exp.pop_front());
                end
            end
            check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
            check("timer_irq", 32'(timer_irq), 32'(m_hit));
        end
    end

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic rdy, input string nm);
        logic [31:0] v;
        MemWrite  = we;
        Addr      = a;
        WriteData = wd;
        tx_ready  = rdy;
        if (!reset && model_read(a, v)) begin
            rd_exp.push_back(v);
            rd_nm.push_back(nm);
            rd_chk = 1'b1;
        end else begin
            rd_chk = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_const(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic rdy, input string nm, input logic [31:0] expv);
        MemWrite  = we;
        Addr      = a;
        WriteData = wd;
        tx_ready  = rdy;
        rd_exp.push_back(expv);
        rd_nm.push_back(nm);
        rd_chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tval;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        step_const(0, A_TM, 0, 0, "rst_timer", 32'h0);
        step_const(0, A_ST, 0, 0, "rst_status", 32'h1);
        step_const(0, A_CMP, 0, 0, "rst_compare", 32'hFFFF_FFFF);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_irq", 32'(timer_irq), 32'd0);

        // RAM store/load and unmapped read
        step(1, 32'h10, 32'hDEAD_BEEF, 0, "ram_store");
        step_const(0, 32'h10, 0, 0, "ram_load", 32'hDEAD_BEEF);
        step_const(0, 32'h13, 0, 0, "ram_load_unaligned", 32'hDEAD_BEEF);
        step_const(0, 32'h8000_0000, 0, 0, "unmapped_load", 32'h0);
        step_const(1, 32'h14, 32'h1234_5678, 0, "ram_rmw_old", 32'h0000_0000 | m_ram_or0(32'h14));
        step_const(0, 32'h14, 0, 0, "ram_rmw_new", 32'h1234_5678);

        // Fill, overflow, in-order drain
        for (int i = 0; i < 8; i++) step(1, A_TX, 32'h41 + i, 0, "tx_push");
        step_const(0, A_ST, 0, 0, "status_full", 32'h82);
        step(1, A_TX, 32'h49, 0, "tx_push_ovf");
        step_const(0, A_ST, 0, 0, "status_ovf", 32'h86);
        for (int i = 0; i < 8; i++) begin
            check("drain_byte", 32'(tx_data), 32'h41 + i);
            step(0, A_ST, 0, 1, "drain_status");
        end
        check("drain_empty", 32'(tx_valid), 32'd0);
        step(1, A_ST, 32'h4, 0, "ovf_clear");
        step_const(0, A_ST, 0, 0, "status_after_clear", 32'h1);

        // Push and pop on a full FIFO
        for (int i = 0; i < 8; i++) step(1, A_TX, 32'h50 + i, 0, "tx_push2");
        step(1, A_TX, 32'h99, 1, "push_pop_full");
        step_const(0, A_ST, 0, 0, "status_push_pop", 32'h82);
        check("push_pop_head", 32'(tx_data), 32'h51);
        for (int i = 0; i < 8; i++) step(0, A_ST, 0, 1, "drain2_status");
        step_const(0, A_ST, 0, 0, "status_drained", 32'h1);

        // Timer compare, clear, wrap
        step(1, A_TM, 32'd100, 0, "timer_load");
        step(1, A_CMP, 32'd105, 0, "compare_load");
        for (int i = 0; i < 5; i++) begin
            check("irq_low", 32'(timer_irq), 32'd0);
            step_const(0, A_TM, 0, 0, "timer_count", 32'd101 + i);
        end
        check("irq_rise", 32'(timer_irq), 32'd1);
        step(1, A_ST, 32'h8, 0, "hit_clear");
        check("irq_cleared", 32'(timer_irq), 32'd0);
        step(1, A_TM, 32'hFFFF_FFFF, 0, "timer_max_load");
        step_const(0, A_TM, 0, 0, "timer_max", 32'hFFFF_FFFF);
        step_const(0, A_TM, 0, 0, "timer_wrap", 32'h0);

        // Set beats clear in the same cycle
        tval = m_timer + 32'd1;
        step(1, A_CMP, tval, 0, "compare_next");
        step(1, A_ST, 32'h8, 0, "hit_clear_vs_set");
        check("set_wins", 32'(timer_irq), 32'd1);
        step(1, A_ST, 32'h8, 0, "hit_clear2");
        check("irq_cleared2", 32'(timer_irq), 32'd0);

        // Reset with bytes queued
        for (int i = 0; i < 3; i++) step(1, A_TX, 32'h60 + i, 0, "tx_push3");
        reset = 1'b1;
        step(1, A_TX, 32'h77, 0, "push_in_reset");
        reset = 1'b0;
        check("mid_reset_tx_valid", 32'(tx_valid), 32'd0);
        step_const(0, A_ST, 0, 0, "mid_reset_status", 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            int          op;
            logic        we;
            logic [31:0] a;
            logic [31:0] d;
            logic        rdy;
            op  = int'($urandom_range(0, 9));
            rdy = ($urandom_range(0, 2) == 0);
            we  = 1'b0;
            d   = $urandom;
            a   = '0;
            case (op)
                0, 1: begin we = 1'b1; a = $urandom_range(0, RAM_WORDS * 4 - 1); end
                2, 3: a = $urandom_range(0, RAM_WORDS * 4 - 1);
                4, 5: begin we = 1'b1; a = A_TX; end
                6: begin we = 1'b1; a = A_ST; end
                7: begin
                    we = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        a = A_CMP;
                        d = m_timer + $urandom_range(0, 6);
                    end else begin
                        a = A_TM;
                        d = m_cmp - $urandom_range(0, 6);
                    end
                end
                8: a = IO_BASE + 32'($urandom_range(0, 15));
                default: begin we = 1'($urandom_range(0, 1)); a = $urandom | 32'h8000_0000; end
            endcase
            step(we, a, d, rdy, "rand");
        end
        for (int i = 0; i < int'(FIFO_DEPTH) + 2; i++) step(0, A_ST, 0, 1, "final_drain");

        rd_chk = 1'b0;
        @(negedge clk);
        check("rd_scoreboard_empty", 32'(rd_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Old contents of a RAM word as the model knows them (zero if never written here).
    function automatic logic [31:0] m_ram_or0(input logic [31:0] a);
        if (m_ram.exists(int'(a >> 2))) return m_ram[int'(a >> 2)];
        return 32'h0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Data-side responder for the single-cycle RISC-V core: it answers the core's MemWrite/address/WriteData/ReadData interface in the same cycle. It decodes each access to one of three targets:
- a word RAM;
- a transmit FIFO drained by an external byte consumer over a valid/ready handshake;
- a free-running timer with a compare interrupt.

It sits beside the core in the top level, on the core's data port.

## Interface
Parameters:
- RAM_WORDS, 64, RAM depth in 32-bit words; power of two, 16..1024.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, 2..8.
- IO_BASE, 32'h0000_FF00, base address of the register window (16 bytes, word-aligned).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  write strobe for the current access.
- Addr  input  32  byte address (core ALUResult); Addr[1:0] ignored.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational from Addr.
- tx_valid  output  1  FIFO non-empty.
- tx_data  output  8  FIFO head byte.
- tx_ready  input  1  consumer accepts head this cycle.
- timer_irq  output  1  sticky compare-hit flag.

## Operation
Address decode:
- RAM when Addr < RAM_WORDS*4; index is Addr[log2(RAM_WORDS)+1:2].
- Register window when Addr[31:4] == IO_BASE[31:4].
- Otherwise unmapped: reads return 0, writes are ignored.

Registers (offset from IO_BASE):
- 0x0 TXDATA
  - Write pushes WriteData[7:0].
  - If full and no pop in the same cycle, the byte is dropped and OVF is set.
  - Read returns 0.
- 0x4 STATUS
  - Read layout: [0] EMPTY, [1] FULL, [2] OVF, [3] HIT, [7:4] count, rest 0.
  - Write: WriteData[2]=1 clears OVF; WriteData[3]=1 clears HIT. Other bits are ignored.
- 0x8 TIMER
  - Increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
  - Write loads WriteData; the next cycle shows WriteData, then counting continues from there.
- 0xC COMPARE
  - Read/write, 32 bits.
  - HIT is set on any cycle where TIMER == COMPARE.

Flag and FIFO rules:
- timer_irq = HIT.
- If a set condition and a clear write occur in the same cycle, set wins. This applies to both OVF and HIT.
- FIFO push and pop in the same cycle:
  - when full: both happen, count unchanged, no OVF;
  - when empty: push only (head is not yet visible).
- Pop occurs when tx_valid && tx_ready. tx_ready while empty has no effect.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reads are combinational and reflect register state before the clock edge. A read of TIMER returns the pre-increment value.
- All writes, pushes, pops and flag updates take effect at the rising edge of clk.
- A pushed byte appears on tx_valid/tx_data the cycle after the push edge.
- tx_data is stable while tx_valid && !tx_ready.
- RAM write takes effect at the edge; a read of the same word in the same cycle returns the old value.
- Reset values:
  - tx_valid 0; FIFO empty with count 0 and both pointers 0.
  - OVF 0, HIT 0, timer_irq 0.
  - TIMER 0, COMPARE 32'hFFFF_FFFF.
  - RAM contents are not reset.
- Reset asserted mid-operation discards FIFO contents on that edge. MemWrite is ignored while reset is high.

## Structure
- Package riscv_bus_pkg holds:
  - register offsets: TXDATA_OFF=4'h0, STATUS_OFF=4'h4, TIMER_OFF=4'h8, COMPARE_OFF=4'hC;
  - STATUS bit positions;
  - an enum for the decoded target: TGT_RAM, TGT_IO, TGT_NONE.
- Sub-module tx_fifo is parameterised by DEPTH and WIDTH=8.
  - Push side: push, full. Pop side: valid, data, ready.
  - It also exports count.
  - Its instance is the only owner of pointer and count state.
- RAM, decode, timer and register logic live in the top level.

## Test plan
- After reset: STATUS reads 32'h1, TIMER reads 0 on the first cycle, COMPARE reads 32'hFFFF_FFFF, tx_valid=0, timer_irq=0.
- RAM store/load:
  - store 32'hDEADBEEF to 0x10, then load 0x10 → 32'hDEADBEEF;
  - load 0x13 → 32'hDEADBEEF;
  - load of an unmapped address such as 32'h8000_0000 → 0.
- FIFO fill and overflow, with tx_ready=0:
  - push 0x41..0x48 → STATUS=32'h82 (count 8, FULL);
  - a ninth push → OVF set, STATUS=32'h86;
  - raise tx_ready → bytes drain 0x41..0x48 in order, one per cycle, then tx_valid falls.
- Full FIFO with tx_ready=1 and a push in the same cycle → head pops, new byte is accepted, count stays 8, OVF stays 0.
- Timer compare:
  - write TIMER=100 and COMPARE=105 → timer_irq rises on the edge where TIMER==105;
  - writing STATUS 32'h8 clears it;
  - TIMER=32'hFFFF_FFFF wraps to 0 on the next cycle.
- Reset asserted with 3 bytes queued → next cycle tx_valid=0 and STATUS=32'h1.
